// File: rtl/array_loader.sv
// array_loader: streams valid/ready fixed-point words into an array
// write port at consecutive addresses, one LENGTH-word load per start.
module array_loader #(
    parameter int ADDR_BITS  = 2,
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 2 ** ADDR_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic                         wr_en,
    output logic [ADDR_BITS-1:0]         wr_addr,
    output logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic                         wr_ready,
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_BITS:0]           count
);

    if (LENGTH < 1 || LENGTH > 2 ** ADDR_BITS) begin : g_bad_length
        $error("array_loader: LENGTH out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [ADDR_BITS:0] LEN = (ADDR_BITS + 1)'(LENGTH);

    state_t               state;
    logic [ADDR_BITS:0]   accepted;
    logic [ADDR_BITS-1:0] next_addr;
    logic                 accept;
    logic                 handshake;

    // The output stage is one register deep, so a new word fits
    // whenever it is empty or being drained this cycle.
    assign in_ready = (state == LOAD)
                   && (accepted < LEN)
                   && (!wr_en || wr_ready);

    assign accept    = in_valid && in_ready;
    assign handshake = wr_en && wr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            accepted  <= '0;
            next_addr <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        accepted  <= '0;
                        next_addr <= '0;
                        count     <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        wr_en <= 1'b0;
                    end else begin
                        if (accept) begin
                            wr_en     <= 1'b1;
                            wr_addr   <= next_addr;
                            wr_data   <= in_data;
                            next_addr <= next_addr + 1'b1;
                            accepted  <= accepted + 1'b1;
                        end else if (handshake) begin
                            wr_en <= 1'b0;
                        end
                        if (handshake) begin
                            count <= count + 1'b1;
                        end
                        if (handshake && count == LEN - 1'b1) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_loader.sv
// Bench for array_loader: a full-length and a short-length instance
// share stimulus and are checked every cycle against a load model.
module tb_array_loader;

    localparam int AB    = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int WDS[4] = '{10, 20, -30, 40};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic in_valid = 1'b0;
    logic wr_ready = 1'b0;
    logic signed [DW-1:0] in_data = '0;

    logic ir[2];
    logic we[2];
    logic bz[2];
    logic dn[2];
    logic [AB-1:0] wa[2];
    logic signed [DW-1:0] wd[2];
    logic [AB:0] cn[2];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    // model: phase 0 idle, 1 load, 2 done; words accepted / written
    int len[2] = '{4, 3};
    int ph[2];
    int macc[2];
    int mwr[2];
    int laddr[2];
    int ldata[2];

    int log_a[2][$];
    int log_d[2][$];
    int log_c[2][$];
    int ndone[2];
    int done_cyc[2];

    array_loader #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .LENGTH(4)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
        .wr_en(we[0]), .wr_addr(wa[0]), .wr_data(wd[0]),
        .wr_ready(wr_ready), .busy(bz[0]), .done(dn[0]), .count(cn[0])
    );

    array_loader #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .LENGTH(3)) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
        .wr_en(we[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
        .wr_ready(wr_ready), .busy(bz[1]), .done(dn[1]), .count(cn[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d",
                     nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int e_ir;
            int e_we;
            int a;
            int w;
            if (!rst) begin
                ph[i] = 0;
                macc[i] = 0;
                mwr[i] = 0;
                laddr[i] = 0;
                ldata[i] = 0;
            end
            e_we = (ph[i] == 1 && macc[i] > mwr[i]) ? 1 : 0;
            e_ir = (ph[i] == 1 && macc[i] < len[i]
                    && (e_we == 0 || wr_ready)) ? 1 : 0;
            chk($sformatf("u%0d.in_ready", i), int'(ir[i]), e_ir);
            chk($sformatf("u%0d.wr_en", i), int'(we[i]), e_we);
            chk($sformatf("u%0d.wr_addr", i), int'(wa[i]), laddr[i]);
            chk($sformatf("u%0d.wr_data", i), int'(wd[i]), ldata[i]);
            chk($sformatf("u%0d.busy", i), int'(bz[i]),
                (ph[i] == 1) ? 1 : 0);
            chk($sformatf("u%0d.done", i), int'(dn[i]),
                (ph[i] == 2) ? 1 : 0);
            chk($sformatf("u%0d.count", i), int'(cn[i]), mwr[i]);
            if (we[i] && wr_ready) begin
                log_a[i].push_back(int'(wa[i]));
                log_d[i].push_back(int'(wd[i]));
                log_c[i].push_back(cyc);
            end
            if (dn[i]) begin
                ndone[i] = ndone[i] + 1;
                done_cyc[i] = cyc;
            end
            if (rst) begin
                case (ph[i])
                    0: if (start) begin
                        ph[i] = 1;
                        macc[i] = 0;
                        mwr[i] = 0;
                    end
                    1: if (abort) begin
                        ph[i] = 0;
                    end else begin
                        w = (e_we == 1 && wr_ready) ? 1 : 0;
                        a = (in_valid && e_ir == 1) ? 1 : 0;
                        if (a == 1) begin
                            laddr[i] = macc[i] % DEPTH;
                            ldata[i] = int'(in_data);
                            macc[i] = macc[i] + 1;
                        end
                        if (w == 1) mwr[i] = mwr[i] + 1;
                        if (mwr[i] == len[i]) ph[i] = 2;
                    end
                    default: ph[i] = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            log_a[i].delete();
            log_d[i].delete();
            log_c[i].delete();
            ndone[i] = 0;
            done_cyc[i] = -1;
        end
    endtask

    // start, then run ncyc cycles with per-cycle valid/ready patterns
    task automatic feed(input logic [31:0] vpat, input logic [31:0] rpat,
                        input int abort_at, input int rst_at,
                        input int ncyc, input int probe_at,
                        output int st, output logic [3:0] probe);
        int k = 0;
        probe = '0;
        start = 1'b1;
        in_valid = 1'b0;
        wr_ready = 1'b1;
        st = cyc;
        tick();
        start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            rst = 1'b1;
            in_valid = vpat[c];
            abort = (c == abort_at);
            wr_ready = abort ? 1'b0 : rpat[c];
            in_data = (k < 4) ? DW'(WDS[k]) : DW'($urandom);
            #2;
            if (c == rst_at) rst = 1'b0;
            #1;
            if (c == rst_at) begin
                for (int i = 0; i < 2; i++) begin
                    chk("rst_in_ready", int'(ir[i]), 0);
                    chk("rst_wr_en", int'(we[i]), 0);
                    chk("rst_wr_addr", int'(wa[i]), 0);
                    chk("rst_wr_data", int'(wd[i]), 0);
                    chk("rst_busy", int'(bz[i]), 0);
                    chk("rst_count", int'(cn[i]), 0);
                end
            end
            if (c == probe_at)
                probe = {we[0], ir[0], ir[1], wa[0] == 2'd1 && wd[0] == 16'sd20};
            if (in_valid && ir[0]) k++;
            tick();
        end
        rst = 1'b1;
        abort = 1'b0;
        in_valid = 1'b0;
        wr_ready = 1'b0;
        tick();
    endtask

    task automatic check_full(input string nm);
        chk({nm, "_writes"}, log_a[0].size(), 4);
        for (int k = 0; k < log_a[0].size() && k < 4; k++) begin
            chk({nm, "_addr"}, log_a[0][k], k);
            chk({nm, "_data"}, log_d[0][k], WDS[k]);
        end
        chk({nm, "_count"}, int'(cn[0]), 4);
        chk({nm, "_done_pulses"}, ndone[0], 1);
    endtask

    initial begin
        int st;
        logic [3:0] pr;

        clear_logs();
        rst = 1'b0;
        repeat (3) tick();
        chk("reset_count", int'(cn[0]), 0);
        rst = 1'b1;
        tick();

        // basic back-to-back load; short instance stops after 3
        clear_logs();
        feed(32'hF, 32'hFFFF_FFFF, -1, -1, 12, 3, st, pr);
        check_full("basic");
        for (int k = 0; k < 3 && k < log_c[0].size(); k++)
            chk("basic_consecutive", log_c[0][k+1] - log_c[0][k], 1);
        chk("basic_done_cycle", done_cyc[0] - st, 6);
        chk("short_writes", log_a[1].size(), 3);
        if (log_a[1].size() == 3)
            chk("short_last_addr", log_a[1][2], 2);
        chk("short_count", int'(cn[1]), 3);
        chk("short_ready_low", int'(pr[1]), 0);
        chk("full_ready_high", int'(pr[2]), 1);

        // array stall while word 20 is pending
        clear_logs();
        feed(32'hFFFF, 32'hFFFF_FFE3, -1, -1, 14, 3, st, pr);
        check_full("stall");
        chk("stall_hold", int'(pr[0]), 1);
        chk("stall_pending", int'(pr[3]), 1);
        chk("stall_ready_low", int'(pr[2]), 0);

        // input gaps: valid 1,0,0,1,0,0,...
        clear_logs();
        feed(32'h249, 32'hFFFF_FFFF, -1, -1, 16, -1, st, pr);
        check_full("gaps");
        for (int k = 0; k < 3 && k < log_c[0].size() - 1; k++)
            chk("gaps_spacing", log_c[0][k+1] - log_c[0][k], 3);

        // abort with two writes done and a third pending
        clear_logs();
        feed(32'h7, 32'hFFFF_FFFF, 3, -1, 8, -1, st, pr);
        chk("abort_writes", log_a[0].size(), 2);
        chk("abort_count", int'(cn[0]), 2);
        chk("abort_no_done", ndone[0], 0);
        chk("abort_wr_en", int'(we[0]), 0);
        chk("abort_busy", int'(bz[0]), 0);
        clear_logs();
        feed(32'hF, 32'hFFFF_FFFF, -1, -1, 12, -1, st, pr);
        check_full("restart");

        // reset asserted mid-load, then a clean load
        clear_logs();
        feed(32'hF, 32'hFFFF_FFFF, -1, 1, 6, -1, st, pr);
        chk("rst_no_writes", log_a[0].size(), 0);
        clear_logs();
        feed(32'hF, 32'hFFFF_FFFF, -1, -1, 12, -1, st, pr);
        check_full("post_rst");

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            wr_ready = abort ? 1'b0 : ($urandom_range(0, 3) != 0);
            in_data = DW'($urandom);
            tick();
        end
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
